// File: rtl/cpu_ctrl_pkg.sv
// Shared types and helpers for the CPU load/run/dump sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        SETTLE,
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wen;
        logic              ren;
    } mem_port_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned       limit);
        return (32'(len) > limit) ? LEN_W'(limit) : len;
    endfunction

    function automatic logic [DATA_W-1:0] word_addr(input logic [LEN_W-1:0] k);
        return DATA_W'(k) * DATA_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= value;
            zero  <= (value == '0);
        end else if (dec && !zero) begin
            count <= count - W'(1);
            zero  <= (count == W'(1));
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Load-run-dump sequencer: streams program/data into the CPU memories,
// enables the CPU for a fixed cycle budget, then streams a data window out.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned CYCLE_W    = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   imem_len,
    input  logic [LEN_W-1:0]   dmem_len,
    input  logic [LEN_W-1:0]   dump_len,
    input  logic [CYCLE_W-1:0] run_cycles,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic [DATA_W-1:0]  addr_ext,
    output logic [DATA_W-1:0]  wdata_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [DATA_W-1:0]  addr_ext_2,
    output logic [DATA_W-1:0]  wdata_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    input  logic [DATA_W-1:0]  rdata_ext_2,
    output logic               cpu_enable,
    output logic               busy,
    output logic               done
);

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    idx, idx_nxt;
    logic [LEN_W-1:0]    dmem_len_q, dump_len_q, imem_clamped;
    logic                latch, xfer, leave_run;
    logic                wc_load, wc_dec, wc_zero;
    logic [LEN_W-1:0]    wc_value, wc_count;
    logic                rc_dec, rc_zero;
    logic [CYCLE_W-1:0]  rc_count;
    mem_port_t           imem_q, imem_nxt, dmem_q, dmem_nxt;
    logic                s_ready_nxt, m_valid_nxt, cpu_enable_nxt, busy_nxt, done_nxt;
    logic [DATA_W-1:0]   m_data_nxt;

    assign imem_clamped = clamp_len(imem_len, IMEM_WORDS);
    assign xfer         = s_valid && s_ready;

    // Words remaining in the current load or dump phase.
    down_counter #(.W(LEN_W)) u_word_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (wc_load),
        .value  (wc_value),
        .dec    (wc_dec),
        .count  (wc_count),
        .zero   (wc_zero)
    );

    down_counter #(.W(CYCLE_W)) u_run_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .load   (latch),
        .value  (run_cycles),
        .dec    (rc_dec),
        .count  (rc_count),
        .zero   (rc_zero)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            idx        <= '0;
            dmem_len_q <= '0;
            dump_len_q <= '0;
            imem_q     <= '0;
            dmem_q     <= '0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            imem_q     <= imem_nxt;
            dmem_q     <= dmem_nxt;
            s_ready    <= s_ready_nxt;
            m_valid    <= m_valid_nxt;
            m_data     <= m_data_nxt;
            cpu_enable <= cpu_enable_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            if (latch) begin
                dmem_len_q <= clamp_len(dmem_len, DMEM_WORDS);
                dump_len_q <= clamp_len(dump_len, DMEM_WORDS);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        latch        = 1'b0;
        leave_run    = 1'b0;
        wc_load      = 1'b0;
        wc_value     = '0;
        wc_dec       = 1'b0;
        rc_dec       = 1'b0;
        imem_nxt     = imem_q;
        imem_nxt.wen = 1'b0;
        imem_nxt.ren = 1'b0;
        dmem_nxt     = dmem_q;
        dmem_nxt.wen = 1'b0;
        dmem_nxt.ren = 1'b0;
        s_ready_nxt  = s_ready;
        m_valid_nxt  = m_valid;
        m_data_nxt   = m_data;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = LOAD_I;
                    latch       = 1'b1;
                    idx_nxt     = '0;
                    wc_load     = 1'b1;
                    wc_value    = imem_clamped;
                    s_ready_nxt = (imem_clamped != '0);
                end
            end
            LOAD_I: begin
                if (xfer) begin
                    imem_nxt.wen  = 1'b1;
                    imem_nxt.addr = word_addr(idx);
                    imem_nxt.data = s_data;
                    idx_nxt       = idx + LEN_W'(1);
                    wc_dec        = 1'b1;
                end
                if (wc_zero || (xfer && wc_count == LEN_W'(1))) begin
                    state_nxt   = LOAD_D;
                    idx_nxt     = '0;
                    wc_load     = 1'b1;
                    wc_value    = dmem_len_q;
                    s_ready_nxt = (dmem_len_q != '0);
                end
            end
            LOAD_D: begin
                if (xfer) begin
                    dmem_nxt.wen  = 1'b1;
                    dmem_nxt.addr = word_addr(idx);
                    dmem_nxt.data = s_data;
                    idx_nxt       = idx + LEN_W'(1);
                    wc_dec        = 1'b1;
                end
                if (wc_zero || (xfer && wc_count == LEN_W'(1))) begin
                    state_nxt   = SETTLE;
                    idx_nxt     = '0;
                    wc_load     = 1'b1;
                    wc_value    = dump_len_q;
                    s_ready_nxt = 1'b0;
                end
            end
            SETTLE: begin
                if (!rc_zero) state_nxt = RUN;
                else          leave_run = 1'b1;
            end
            RUN: begin
                rc_dec = 1'b1;
                if (rc_count == CYCLE_W'(1)) leave_run = 1'b1;
            end
            DUMP_RD: begin
                state_nxt = DUMP_OUT;
            end
            DUMP_OUT: begin
                // Read data lands the cycle after the strobe; capture once, then offer it.
                if (!m_valid) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = rdata_ext_2;
                end else if (m_ready) begin
                    m_valid_nxt = 1'b0;
                    if (wc_count == LEN_W'(1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt     = DUMP_RD;
                        wc_dec        = 1'b1;
                        idx_nxt       = idx + LEN_W'(1);
                        dmem_nxt.ren  = 1'b1;
                        dmem_nxt.addr = word_addr(idx_nxt);
                    end
                end
            end
        endcase

        if (leave_run) begin
            if (!wc_zero) begin
                state_nxt     = DUMP_RD;
                dmem_nxt.ren  = 1'b1;
                dmem_nxt.addr = word_addr(idx);
            end else begin
                state_nxt = DONE;
            end
        end

        cpu_enable_nxt = (state_nxt == RUN);
        busy_nxt       = !((state_nxt == IDLE) || (state_nxt == DONE));
        done_nxt       = (state_nxt == DONE);
    end

    assign addr_ext    = imem_q.addr;
    assign wdata_ext   = imem_q.data;
    assign wen_ext     = imem_q.wen;
    assign ren_ext     = imem_q.ren;
    assign addr_ext_2  = dmem_q.addr;
    assign wdata_ext_2 = dmem_q.data;
    assign wen_ext_2   = dmem_q.wen;
    assign ren_ext_2   = dmem_q.ren;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a synchronous-read data memory model.
module tb_cpu_run_controller;

    localparam int unsigned CYCLE_W = 32;

    logic               clk        = 1'b0;
    logic               arst_n     = 1'b0;
    logic               start      = 1'b0;
    logic [15:0]        imem_len   = '0;
    logic [15:0]        dmem_len   = '0;
    logic [15:0]        dump_len   = '0;
    logic [CYCLE_W-1:0] run_cycles = '0;
    logic               s_valid    = 1'b0;
    logic               s_ready;
    logic [31:0]        s_data;
    logic               m_valid;
    logic               m_ready    = 1'b0;
    logic [31:0]        m_data;
    logic [31:0]        addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic               wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0]        rdata_ext_2 = '0;
    logic               cpu_enable, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0, hs_cnt = 0, last_hs_cyc = 0;
    int en_cnt = 0, en_rise = 0, en_rise_cyc = 0, overlap = 0, ren_cnt = 0;
    logic en_prev = 1'b0;
    logic [31:0] iw_addr[$], iw_data[$], dw_addr[$], dw_data[$], m_words[$];
    logic [31:0] dmem [0:1023];

    cpu_run_controller dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_len    (imem_len),
        .dmem_len    (dmem_len),
        .dump_len    (dump_len),
        .run_cycles  (run_cycles),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .addr_ext    (addr_ext),
        .wdata_ext   (wdata_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .addr_ext_2  (addr_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Source word n of the load stream carries tag A5A5 and index n.
    assign s_data = 32'hA5A5_0000 + 32'(hs_cnt);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_prev <= cpu_enable;
        if (s_valid && s_ready) begin
            hs_cnt      <= hs_cnt + 1;
            last_hs_cyc <= cyc;
        end
        if (cpu_enable) en_cnt <= en_cnt + 1;
        if (cpu_enable && !en_prev) begin
            en_rise     <= en_rise + 1;
            en_rise_cyc <= cyc;
        end
        if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) overlap <= overlap + 1;
        if (ren_ext_2) begin
            ren_cnt     <= ren_cnt + 1;
            rdata_ext_2 <= dmem[addr_ext_2[11:2]];
        end
        if (wen_ext) begin
            iw_addr.push_back(addr_ext);
            iw_data.push_back(wdata_ext);
        end
        if (wen_ext_2) begin
            dw_addr.push_back(addr_ext_2);
            dw_data.push_back(wdata_ext_2);
            dmem[addr_ext_2[11:2]] <= wdata_ext_2;
        end
        if (m_valid && m_ready) m_words.push_back(m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_enable(input string tag, input int budget);
        int n = 0;
        while (cpu_enable !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(cpu_enable), 64'd1);
    endtask

    task automatic wait_mvalid(input string tag);
        int n = 0;
        while (m_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 64'(m_valid), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 64'({s_ready, m_valid, cpu_enable, wen_ext, ren_ext,
                                    wen_ext_2, ren_ext_2, busy, done}), 64'd0);
        check({tag, "_addr"}, {addr_ext, addr_ext_2}, 64'd0);
        check({tag, "_wdata"}, {wdata_ext, wdata_ext_2}, 64'd0);
        check({tag, "_mdata"}, 64'(m_data), 64'd0);
    endtask

    initial begin
        int qi, qd, qm, e0, r0, rc0;

        #3;
        check_all_zero("rst");
        #4 arst_n = 1'b1;
        tick();

        // A: 3 imem + 2 dmem words, 5 run cycles, 2-word dump with m_ready high.
        imem_len = 16'd3; dmem_len = 16'd2; dump_len = 16'd2; run_cycles = 32'd5;
        s_valid = 1'b1; m_ready = 1'b1;
        qi = iw_addr.size(); qd = dw_addr.size(); qm = m_words.size();
        e0 = en_cnt; r0 = en_rise;
        pulse_start();
        check("A_busy", 64'(busy), 64'd1);
        check("A_sready", 64'(s_ready), 64'd1);
        wait_done("A_done", 100);
        s_valid = 1'b0;
        check("A_iw_count", 64'(iw_addr.size() - qi), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("A_iw_addr%0d", i), 64'(iw_addr[qi + i]), 64'(32'(i * 4)));
            check($sformatf("A_iw_data%0d", i), 64'(iw_data[qi + i]), 64'(32'hA5A5_0000 + 32'(i)));
        end
        check("A_dw_count", 64'(dw_addr.size() - qd), 64'd2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("A_dw_addr%0d", i), 64'(dw_addr[qd + i]), 64'(32'(i * 4)));
            check($sformatf("A_dw_data%0d", i), 64'(dw_data[qd + i]), 64'(32'hA5A5_0003 + 32'(i)));
        end
        check("A_en_cycles", 64'(en_cnt - e0), 64'd5);
        check("A_en_rises", 64'(en_rise - r0), 64'd1);
        check("A_en_latency", 64'(en_rise_cyc - last_hs_cyc), 64'd2);
        check("A_dump_count", 64'(m_words.size() - qm), 64'd2);
        for (int i = 0; i < 2; i++)
            check($sformatf("A_dump%0d", i), 64'(m_words[qm + i]), 64'(32'hA5A5_0003 + 32'(i)));
        check("A_busy_end", 64'(busy), 64'd0);

        // B: 4 dmem words, 4-word dump with a stall on word 1.
        imem_len = 16'd0; dmem_len = 16'd4; dump_len = 16'd4; run_cycles = 32'd2;
        m_ready = 1'b0;
        qi = iw_addr.size(); qm = m_words.size();
        pulse_start();
        tick();
        s_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            wait_mvalid($sformatf("B_mvalid%0d", w));
            if (w == 1) begin
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("B_stall_valid", 64'(m_valid), 64'd1);
                    check("B_stall_data", 64'(m_data), 64'h0000_0000_A5A5_0006);
                end
            end
            check($sformatf("B_word%0d", w), 64'(m_data), 64'(32'hA5A5_0005 + 32'(w)));
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check($sformatf("B_mvalid_drop%0d", w), 64'(m_valid), 64'd0);
        end
        s_valid = 1'b0;
        check("B_done", 64'(done), 64'd1);
        check("B_dump_count", 64'(m_words.size() - qm), 64'd4);
        check("B_no_imem_wr", 64'(iw_addr.size() - qi), 64'd0);

        // C: everything zero walks LOAD_I, LOAD_D, SETTLE, DONE with no activity.
        imem_len = 16'd0; dmem_len = 16'd0; dump_len = 16'd0; run_cycles = 32'd0;
        qi = iw_addr.size(); qd = dw_addr.size(); e0 = en_cnt; rc0 = ren_cnt;
        pulse_start();
        check("C_c1_busy_done", 64'({busy, done, s_ready}), 64'b100);
        tick();
        check("C_c2_busy_done", 64'({busy, done}), 64'b10);
        tick();
        check("C_c3_busy_done", 64'({busy, done}), 64'b10);
        tick();
        check("C_c4_busy_done", 64'({busy, done}), 64'b01);
        check("C_no_imem_wr", 64'(iw_addr.size() - qi), 64'd0);
        check("C_no_dmem_wr", 64'(dw_addr.size() - qd), 64'd0);
        check("C_no_rd", 64'(ren_cnt - rc0), 64'd0);
        check("C_no_enable", 64'(en_cnt - e0), 64'd0);

        // D: imem length clamps to 512; start during RUN is ignored.
        imem_len = 16'd600; dmem_len = 16'd0; dump_len = 16'd0; run_cycles = 32'd10;
        s_valid = 1'b1;
        qi = iw_addr.size(); e0 = en_cnt; r0 = en_rise;
        pulse_start();
        wait_enable("D_enable", 700);
        s_valid = 1'b0;
        tick();
        pulse_start();
        wait_done("D_done", 50);
        check("D_iw_count", 64'(iw_addr.size() - qi), 64'd512);
        check("D_iw_first", 64'(iw_addr[qi]), 64'd0);
        check("D_iw_last", 64'(iw_addr[iw_addr.size() - 1]), 64'd2044);
        check("D_en_cycles", 64'(en_cnt - e0), 64'd10);
        check("D_en_rises", 64'(en_rise - r0), 64'd1);
        tick();
        check("D_idle_after", 64'({busy, done}), 64'b01);
        check("D_no_overlap", 64'(overlap), 64'd0);

        // E: reset 40 cycles into a 100-cycle run.
        imem_len = 16'd0; dmem_len = 16'd0; dump_len = 16'd0; run_cycles = 32'd100;
        pulse_start();
        wait_enable("E_enable", 20);
        e0 = en_cnt;
        repeat (40) tick();
        check("E_pre_reset_en", 64'(cpu_enable), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        check("E_en_cycles", 64'(en_cnt - e0), 64'd40);
        check_all_zero("E_rst");
        #3 arst_n = 1'b1;
        repeat (3) tick();
        check("E_idle", 64'({busy, done, cpu_enable, s_ready}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Sequencer for the single-cycle/pipelined CPU top: owns both external memory ports and the `enable` input of `cpu`. On `start` it streams a program into instruction memory and an initial image into data memory, runs the CPU for a programmed number of cycles, then streams a window of data memory back out. It replaces testbench-driven preload/dump with a synthesizable, handshaked load–run–dump flow.

## Interface
- `IMEM_WORDS`, 512, instruction memory depth in words; longer load lengths clamp to this
- `DMEM_WORDS`, 1024, data memory depth in words; longer load/dump lengths clamp to this
- `CYCLE_W`, 32, width of the run-cycle budget

- `clk`  in  1  single clock; all logic rising-edge
- `arst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a load–run–dump sequence; sampled only in IDLE or DONE
- `imem_len`  in  16  instruction words to load; latched on accepted `start`
- `dmem_len`  in  16  data words to load; latched on accepted `start`
- `dump_len`  in  16  data words to dump from word 0; latched on accepted `start`
- `run_cycles`  in  CYCLE_W  cycles `cpu_enable` stays high; latched on accepted `start`
- `s_valid` / `s_ready` / `s_data`  in / out / in  1/1/32  load stream: imem words, then dmem words
- `m_valid` / `m_ready` / `m_data`  out / in / out  1/1/32  dump stream
- `addr_ext`, `wdata_ext`  out  32  instruction memory external port
- `wen_ext`, `ren_ext`  out  1  instruction memory external strobes (`ren_ext` tied 0)
- `addr_ext_2`, `wdata_ext_2`  out  32  data memory external port
- `wen_ext_2`, `ren_ext_2`  out  1  data memory external strobes
- `rdata_ext_2`  in  32  data memory external read data
- `cpu_enable`  out  1  drives `cpu.enable`
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  high in DONE

## Operation
- States: IDLE, LOAD_I, LOAD_D, SETTLE, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE/DONE + `start` → LOAD_I; lengths latched (clamped), word index cleared. Zero length skips that phase: LOAD_I→LOAD_D→SETTLE.
- LOAD_I/LOAD_D: `s_ready`=1; each `s_valid&&s_ready` writes `s_data` to word index k, byte address k<<2 (both memories); index increments; after last word, index clears and the FSM advances.
- SETTLE: one cycle for the final write strobe to land; then RUN, or DUMP_RD if `run_cycles`==0.
- RUN: `cpu_enable`=1 exactly `run_cycles` cycles (down-counter); then DUMP_RD, or DONE if `dump_len`==0.
- DUMP_RD: `ren_ext_2`=1, `addr_ext_2`=k<<2 for one cycle → DUMP_OUT.
- DUMP_OUT: `m_data` captures `rdata_ext_2` on entry and holds; `m_valid`=1 until `m_ready`; on handshake, index increments → DUMP_RD, or DONE after last word.
- `start` outside IDLE/DONE ignored. Stream inputs ignored outside load states.

## Timing
- Reset: state IDLE; all outputs 0 (`s_ready`, `m_valid`, `cpu_enable`, all strobes, addresses, data, `busy`, `done`); counters 0. Asserting `arst_n` mid-sequence aborts immediately: `cpu_enable` and strobes drop asynchronously.
- All memory-port outputs registered: handshake in cycle n → `wen_ext`/`wen_ext_2` high with matching address/data in cycle n+1 only.
- Last load handshake cycle n → SETTLE n+1 (final strobe) → `cpu_enable` first high n+2.
- Data memory read latency: 1 cycle; `rdata_ext_2` sampled the cycle after `ren_ext_2`.
- Dump throughput: at most one word per 2 cycles; `m_data` stable while `m_valid && !m_ready`.
- `cpu_enable` never high while any external strobe is high.
- Counters width-safe: 16-bit lengths, CYCLE_W run counter, no wrap within a phase.

## Structure
- Package `cpu_ctrl_pkg`: state enum, `WORD_BYTES`=4, length width constant.
- Sub-module `down_counter` (parameterized width, load/decrement/zero flag), instantiated for run cycles and phase word counts.

## Test plan
- Reset mid-RUN (`run_cycles`=100, reset at cycle 40) → `cpu_enable`=0 immediately, state IDLE, all outputs 0.
- `imem_len`=3, `dmem_len`=2, `s_valid` always high → `wen_ext` at addresses 0,4,8, then `wen_ext_2` at 0,4; `cpu_enable` rises 2 cycles after last handshake.
- `run_cycles`=5 → `cpu_enable` high exactly 5 consecutive cycles.
- `dump_len`=4, `m_ready` low 3 cycles on word 1 → words 0..3 emitted in order, `m_data` held during stall, `done`=1 after word 3.
- All lengths 0, `run_cycles`=0 → IDLE→LOAD_I→LOAD_D→SETTLE→DONE, no strobes, no `cpu_enable`.
- `imem_len`=600 with `IMEM_WORDS`=512 → exactly 512 writes, last at byte address 2044; `start` pulsed during RUN ignored.
